mem_write_scoreboard: RTL and testbench

- Synthesizable, parametrised checker for processor data-memory write traffic. It is the successor to the fixed two-entry expected-write check in the MIPS benches.
- Taps memwrite/dataadr/writedata at the top level of the single-cycle or pipelined core.
- Holds a loadable table of up to DEPTH expected (address, data) writes and compares every observed write against it, in ordered or unordered mode.
- Reports per-write errors, running counts, a timeout and a final pass/fail verdict. Usable in simulation and on FPGA (LED/ILA).

---
 rtl/mem_write_scoreboard.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_write_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_scoreboard.sv
// Checks observed data-memory writes against a loadable table of expected (address, data)
// pairs, in table order or any order, and reports per-write errors, counts and a final verdict.
module mem_write_scoreboard #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned STOP_ON_ERR = 0,
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_ordered,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  exp_count,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [15:0]       mismatch_cnt,
  output logic              err_valid,
  output logic [IDX_W-1:0]  err_idx,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
);

  localparam int unsigned      CYC_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CYC_W-1:0] TO_VAL  = CYC_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [15:0]      MIS_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Expected-write table; contents are don't-care until loaded, so no reset.
  logic [ADDR_W-1:0] r_tab_addr [DEPTH];
  logic [DATA_W-1:0] r_tab_data [DEPTH];

  state_t            r_state;
  logic              r_ordered;
  logic [CNT_W-1:0]  r_exp_cnt;
  logic [CYC_W-1:0]  r_cyc;
  logic [DEPTH-1:0]  r_consumed;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [15:0]       r_mismatch_cnt;
  logic              r_err_valid;
  logic [IDX_W-1:0]  r_err_idx;
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_data;

  state_t            w_state_nxt;
  logic              w_ordered_nxt;
  logic [CNT_W-1:0]  w_exp_nxt;
  logic [CYC_W-1:0]  w_cyc_nxt;
  logic [DEPTH-1:0]  w_consumed_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_pass_nxt;
  logic              w_timeout_nxt;
  logic [CNT_W-1:0]  w_match_nxt;
  logic [15:0]       w_mis_nxt;
  logic              w_err_valid_nxt;
  logic [IDX_W-1:0]  w_err_idx_nxt;
  logic [ADDR_W-1:0] w_err_addr_nxt;
  logic [DATA_W-1:0] w_err_data_nxt;

  logic [CNT_W-1:0]  w_exp_clamp;
  logic [IDX_W-1:0]  w_ord_idx;
  logic              w_ord_eq;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;
  logic              w_is_err;

  always_ff @(posedge clk) begin
    if (load_en && (r_state != S_RUN)) begin
      r_tab_addr[load_idx] <= load_addr;
      r_tab_data[load_idx] <= load_data;
    end
  end

  assign w_exp_clamp = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
  assign w_ord_idx   = IDX_W'(r_match_cnt);
  assign w_ord_eq    = (r_tab_addr[w_ord_idx] == dataadr) && (r_tab_data[w_ord_idx] == writedata);

  // Unordered search: scan high-to-low so the lowest matching free entry wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < r_exp_cnt) && !r_consumed[i] &&
          (r_tab_addr[i] == dataadr) && (r_tab_data[i] == writedata)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ordered_nxt   = r_ordered;
    w_exp_nxt       = r_exp_cnt;
    w_cyc_nxt       = r_cyc;
    w_consumed_nxt  = r_consumed;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_pass_nxt      = r_pass;
    w_timeout_nxt   = r_timeout;
    w_match_nxt     = r_match_cnt;
    w_mis_nxt       = r_mismatch_cnt;
    w_err_valid_nxt = 1'b0;
    w_err_idx_nxt   = r_err_idx;
    w_err_addr_nxt  = r_err_addr;
    w_err_data_nxt  = r_err_data;
    w_is_err        = 1'b0;

    case (r_state)
      S_RUN: begin
        w_cyc_nxt = r_cyc + CYC_W'(1);
        if (memwrite) begin
          if (r_ordered) begin
            if (w_ord_eq) begin
              w_match_nxt = r_match_cnt + CNT_W'(1);
            end else begin
              w_is_err      = 1'b1;
              w_err_idx_nxt = w_ord_idx;
            end
          end else if (w_hit) begin
            w_consumed_nxt[w_hit_idx] = 1'b1;
            w_match_nxt               = r_match_cnt + CNT_W'(1);
          end else begin
            w_is_err      = 1'b1;
            w_err_idx_nxt = '0;
          end
        end

        if (w_is_err) begin
          w_mis_nxt       = (r_mismatch_cnt == MIS_MAX) ? MIS_MAX : r_mismatch_cnt + 16'd1;
          w_err_valid_nxt = 1'b1;
          w_err_addr_nxt  = dataadr;
          w_err_data_nxt  = writedata;
        end

        // A final match takes priority over a simultaneous timeout.
        if (w_match_nxt == r_exp_cnt) begin
          w_state_nxt   = S_DONE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_pass_nxt    = (w_mis_nxt == 16'd0);
          w_timeout_nxt = 1'b0;
        end else if ((STOP_ON_ERR != 0) && w_is_err) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
        end else if ((TIMEOUT != 0) && (w_cyc_nxt == TO_VAL)) begin
          w_state_nxt   = S_DONE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end
      end

      default: begin
        if (start) begin
          w_ordered_nxt  = cfg_ordered;
          w_exp_nxt      = w_exp_clamp;
          w_cyc_nxt      = '0;
          w_consumed_nxt = '0;
          w_match_nxt    = '0;
          w_mis_nxt      = '0;
          w_timeout_nxt  = 1'b0;
          w_err_idx_nxt  = '0;
          w_err_addr_nxt = '0;
          w_err_data_nxt = '0;
          if (w_exp_clamp == '0) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_ordered      <= 1'b0;
      r_exp_cnt      <= '0;
      r_cyc          <= '0;
      r_consumed     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_err_valid    <= 1'b0;
      r_err_idx      <= '0;
      r_err_addr     <= '0;
      r_err_data     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ordered      <= w_ordered_nxt;
      r_exp_cnt      <= w_exp_nxt;
      r_cyc          <= w_cyc_nxt;
      r_consumed     <= w_consumed_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_pass         <= w_pass_nxt;
      r_timeout      <= w_timeout_nxt;
      r_match_cnt    <= w_match_nxt;
      r_mismatch_cnt <= w_mis_nxt;
      r_err_valid    <= w_err_valid_nxt;
      r_err_idx      <= w_err_idx_nxt;
      r_err_addr     <= w_err_addr_nxt;
      r_err_data     <= w_err_data_nxt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign match_cnt    = r_match_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign err_valid    = r_err_valid;
  assign err_idx      = r_err_idx;
  assign err_addr     = r_err_addr;
  assign err_data     = r_err_data;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Bench for mem_write_scoreboard: directed scenarios plus randomized traffic against a
// behavioural model; instance a has a 50-cycle timeout, instance b stops on first error.
module tb_mem_write_scoreboard;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int          DEP = 8;
  localparam int unsigned IW  = 3;
  localparam int unsigned CW  = 4;

  logic          clk;
  logic          reset;
  logic          cfg_ordered;
  logic          load_en;
  logic [IW-1:0] load_idx;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [CW-1:0] exp_count;
  logic          start;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;

  logic busy_a, done_a, pass_a, to_a, ev_a;
  logic busy_b, done_b, pass_b, to_b, ev_b;
  logic [CW-1:0] mc_a, mc_b;
  logic [15:0]   mm_a, mm_b;
  logic [IW-1:0] ei_a, ei_b;
  logic [AW-1:0] ea_a, ea_b;
  logic [DW-1:0] ed_a, ed_b;

  mem_write_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .TIMEOUT(50), .STOP_ON_ERR(0)) u_a (
    .clk(clk), .reset(reset), .cfg_ordered(cfg_ordered), .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data), .exp_count(exp_count), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .busy(busy_a), .done(done_a),
    .pass(pass_a), .timeout(to_a), .match_cnt(mc_a), .mismatch_cnt(mm_a), .err_valid(ev_a),
    .err_idx(ei_a), .err_addr(ea_a), .err_data(ed_a));

  mem_write_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .TIMEOUT(0), .STOP_ON_ERR(1)) u_b (
    .clk(clk), .reset(reset), .cfg_ordered(cfg_ordered), .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data), .exp_count(exp_count), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .busy(busy_b), .done(done_b),
    .pass(pass_b), .timeout(to_b), .match_cnt(mc_b), .mismatch_cnt(mm_b), .err_valid(ev_b),
    .err_idx(ei_b), .err_addr(ea_b), .err_data(ed_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model, one slot per instance: k=0 timeout 50, k=1 stop-on-error.
  logic [31:0] m_ta [2][8];
  logic [31:0] m_td [2][8];
  bit          m_used [2][8];
  bit          m_busy [2], m_done [2], m_pass [2], m_to [2], m_ev [2], m_ord [2];
  int          m_n [2], m_match [2], m_mis [2], m_cyc [2], m_eidx [2];
  logic [31:0] m_ea [2], m_ed [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_to[k] = 0; m_ev[k] = 0; m_ord[k] = 0;
      m_n[k] = 0; m_match[k] = 0; m_mis[k] = 0; m_cyc[k] = 0; m_eidx[k] = 0;
      m_ea[k] = '0; m_ed[k] = '0;
      for (int i = 0; i < 8; i++) m_used[k][i] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_ev[k] = 0;
      if (!m_busy[k]) begin
        if (start) begin
          m_n[k]     = (int'(exp_count) > DEP) ? DEP : int'(exp_count);
          m_ord[k]   = cfg_ordered;
          m_match[k] = 0; m_mis[k] = 0; m_cyc[k] = 0; m_to[k] = 0;
          m_eidx[k]  = 0; m_ea[k] = '0; m_ed[k] = '0;
          for (int i = 0; i < 8; i++) m_used[k][i] = 0;
          if (m_n[k] == 0) begin
            m_done[k] = 1; m_pass[k] = 1;
          end else begin
            m_busy[k] = 1; m_done[k] = 0; m_pass[k] = 0;
          end
        end
        if (load_en) begin
          m_ta[k][load_idx] = load_addr;
          m_td[k][load_idx] = load_data;
        end
      end else begin
        bit err;
        int hit;
        err = 0;
        m_cyc[k]++;
        if (memwrite) begin
          if (m_ord[k]) begin
            if (m_ta[k][m_match[k]] == dataadr && m_td[k][m_match[k]] == writedata) m_match[k]++;
            else begin err = 1; m_eidx[k] = m_match[k]; end
          end else begin
            hit = -1;
            for (int i = 0; i < m_n[k]; i++)
              if (hit < 0 && !m_used[k][i] && m_ta[k][i] == dataadr && m_td[k][i] == writedata) hit = i;
            if (hit >= 0) begin m_used[k][hit] = 1; m_match[k]++; end
            else begin err = 1; m_eidx[k] = 0; end
          end
        end
        if (err) begin
          if (m_mis[k] < 65535) m_mis[k]++;
          m_ev[k] = 1; m_ea[k] = dataadr; m_ed[k] = writedata;
        end
        if (m_match[k] == m_n[k]) begin
          m_busy[k] = 0; m_done[k] = 1; m_pass[k] = (m_mis[k] == 0); m_to[k] = 0;
        end else if (k == 1 && err) begin
          m_busy[k] = 0; m_done[k] = 1; m_pass[k] = 0;
        end else if (k == 0 && m_cyc[k] == 50) begin
          m_busy[k] = 0; m_done[k] = 1; m_pass[k] = 0; m_to[k] = 1;
        end
      end
    end
  endtask

  task automatic check_inst(input string p, input int k, input logic b, input logic d, input logic ps,
                            input logic t, input logic [CW-1:0] mc, input logic [15:0] mm,
                            input logic ev, input logic [IW-1:0] ei, input logic [31:0] ea,
                            input logic [31:0] ed);
    chk({p, ".busy"},    64'(b),  64'(m_busy[k]));
    chk({p, ".done"},    64'(d),  64'(m_done[k]));
    chk({p, ".pass"},    64'(ps), 64'(m_pass[k]));
    chk({p, ".timeout"}, 64'(t),  64'(m_to[k]));
    chk({p, ".match"},   64'(mc), 64'(m_match[k]));
    chk({p, ".mismatch"},64'(mm), 64'(m_mis[k]));
    chk({p, ".err_v"},   64'(ev), 64'(m_ev[k]));
    chk({p, ".err_idx"}, 64'(ei), 64'(m_eidx[k]));
    chk({p, ".err_addr"},64'(ea), 64'(m_ea[k]));
    chk({p, ".err_data"},64'(ed), 64'(m_ed[k]));
  endtask

  task automatic check_all();
    check_inst("a", 0, busy_a, done_a, pass_a, to_a, mc_a, mm_a, ev_a, ei_a, ea_a, ed_a);
    check_inst("b", 1, busy_b, done_b, pass_b, to_b, mc_b, mm_b, ev_b, ei_b, ea_b, ed_b);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst.busy_a", 64'(busy_a), 64'd0);
    chk("rst.match_b", 64'(mc_b), 64'd0);
    #2;
    reset = 1'b1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_idx = IW'(idx); load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic start_run(input logic ord, input int n);
    cfg_ordered = ord; exp_count = CW'(n); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    return 32'h50 + 32'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1; cfg_ordered = 1'b0; load_en = 1'b0; load_idx = '0; load_addr = '0;
    load_data = '0; exp_count = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #10 reset = 1'b1;

    load(0, 32'h50, 32'd7);
    load(1, 32'h54, 32'd7);
    for (int i = 2; i < 8; i++) load(i, pick_addr(), 32'($urandom_range(0, 3)));

    // In-order writes against an ordered table.
    start_run(1'b1, 2);
    chk("t1.busy", 64'(busy_a), 64'd1);
    wr(32'h50, 32'd7);
    wr(32'h54, 32'd7);
    chk("t1.match", 64'(mc_a), 64'd2);
    chk("t1.done", 64'(done_a), 64'd1);
    chk("t1.pass", 64'(pass_a), 64'd1);
    chk("t1.mis", 64'(mm_a), 64'd0);

    // Out-of-order writes in ordered mode; also a rerun without reload.
    start_run(1'b1, 2);
    wr(32'h54, 32'd7);
    chk("t2.err_v", 64'(ev_a), 64'd1);
    chk("t2.err_idx", 64'(ei_a), 64'd0);
    chk("t2.err_addr", 64'(ea_a), 64'h54);
    wr(32'h50, 32'd7);
    chk("t2.match1", 64'(mc_a), 64'd1);
    wr(32'h54, 32'd7);
    chk("t2.match2", 64'(mc_a), 64'd2);
    chk("t2.mis", 64'(mm_a), 64'd1);
    chk("t2.done", 64'(done_a), 64'd1);
    chk("t2.pass", 64'(pass_a), 64'd0);

    // Unordered, back-to-back writes.
    start_run(1'b0, 2);
    memwrite = 1'b1; dataadr = 32'h54; writedata = 32'd7;
    step();
    chk("t3.match1", 64'(mc_a), 64'd1);
    dataadr = 32'h50;
    step();
    memwrite = 1'b0;
    chk("t3.match2", 64'(mc_a), 64'd2);
    chk("t3.pass", 64'(pass_a), 64'd1);

    // Timeout 50 cycles after RUN entry.
    start_run(1'b1, 2);
    wr(32'h50, 32'd7);
    repeat (48) step();
    chk("t4.early_done", 64'(done_a), 64'd0);
    step();
    chk("t4.done", 64'(done_a), 64'd1);
    chk("t4.timeout", 64'(to_a), 64'd1);
    chk("t4.pass", 64'(pass_a), 64'd0);
    chk("t4.match", 64'(mc_a), 64'd1);

    // Stop on first error, then reset mid-run.
    do_reset();
    start_run(1'b1, 1);
    wr(32'h50, 32'd8);
    chk("t5.done_b", 64'(done_b), 64'd1);
    chk("t5.pass_b", 64'(pass_b), 64'd0);
    chk("t5.err_data_b", 64'(ed_b), 64'd8);
    chk("t5.busy_a", 64'(busy_a), 64'd1);
    start_run(1'b1, 2);
    wr(32'h50, 32'd7);
    chk("t5.match_b", 64'(mc_b), 64'd1);
    do_reset();

    // Empty expectation finishes immediately with a pass.
    start_run(1'b0, 0);
    chk("t6.done", 64'(done_a), 64'd1);
    chk("t6.pass", 64'(pass_a), 64'd1);
    chk("t6.busy", 64'(busy_a), 64'd0);

    for (int it = 0; it < 2500; it++) begin
      int r;
      if ($urandom_range(0, 299) == 0) do_reset();
      load_en     = ($urandom_range(0, 4) == 0);
      load_idx    = IW'($urandom_range(0, 7));
      load_addr   = pick_addr();
      load_data   = 32'($urandom_range(0, 3));
      start       = ($urandom_range(0, 9) == 0);
      cfg_ordered = 1'($urandom_range(0, 1));
      exp_count   = CW'($urandom_range(0, 11));
      memwrite    = 1'($urandom_range(0, 1));
      r           = int'($urandom_range(0, 3));
      if (r == 0) begin
        dataadr = pick_addr(); writedata = 32'($urandom_range(0, 3));
      end else if (r == 1) begin
        dataadr = m_ta[0][m_match[0] % 8]; writedata = m_td[0][m_match[0] % 8];
      end else begin
        r = int'($urandom_range(0, 7));
        dataadr = m_ta[0][r]; writedata = m_td[0][r];
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
